// File: rtl/river_pkg.sv
// Shared fetch-predictor defaults and the return-address-stack
// checkpoint bundle carried by branch tags.
package river_pkg;

  localparam int RET_STACK_SIZE        = 16;
  localparam int RET_PRED_POINTER_SIZE = $clog2(RET_STACK_SIZE);
  localparam int RET_PRED_COUNT_SIZE   = $clog2(RET_STACK_SIZE + 1);
  localparam int RET_ADDR_SIZE         = 32;

  typedef struct packed {
    logic [RET_PRED_POINTER_SIZE-1:0] ptr;
    logic [RET_PRED_COUNT_SIZE-1:0]   cnt;
    logic [RET_ADDR_SIZE-1:0]         top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_storage.sv
// Return-stack entry array: one synchronous write port and one
// asynchronous read port; contents are never reset.
module ras_storage #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with checkpoint restore for the
// fetch-stage predictor; restore wins over push/pop.
module ret_addr_stack
  import river_pkg::*;
#(
  parameter int DEPTH  = RET_STACK_SIZE,
  parameter int ADDR_W = RET_ADDR_SIZE,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] top_addr_o,
  output logic              top_vld_o,
  output logic [PTR_W-1:0]  ckpt_ptr_o,
  output logic [CNT_W-1:0]  ckpt_cnt_o,
  output logic [ADDR_W-1:0] ckpt_top_o,
  input  logic              restore_i,
  input  logic [PTR_W-1:0]  restore_ptr_i,
  input  logic [CNT_W-1:0]  restore_cnt_i,
  input  logic [ADDR_W-1:0] restore_top_i
);

  logic [PTR_W-1:0]  ptr, ptr_n, top_idx;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              vld, full;
  logic              do_rst, do_swap, do_push, do_pop;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] wdata, rdata;

  assign vld     = (cnt != '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign top_idx = ptr - 1'b1;

  // One-hot action decode; push+pop on empty degrades to push.
  assign do_rst  = restore_i;
  assign do_swap = !restore_i && push_i && pop_i && vld;
  assign do_push = !restore_i && push_i && !(pop_i && vld);
  assign do_pop  = !restore_i && !push_i && pop_i && vld;

  always_comb begin
    ptr_n = ptr;
    cnt_n = cnt;
    we    = 1'b0;
    waddr = ptr;
    wdata = push_addr_i;
    unique case (1'b1)
      do_rst: begin
        ptr_n = restore_ptr_i;
        cnt_n = restore_cnt_i;
        we    = (restore_cnt_i != '0);
        waddr = restore_ptr_i - 1'b1;
        wdata = restore_top_i;
      end
      do_swap: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      do_push: begin
        we    = 1'b1;
        ptr_n = ptr + 1'b1;
        cnt_n = full ? cnt : cnt + 1'b1;
      end
      do_pop: begin
        ptr_n = top_idx;
        cnt_n = cnt - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end

  ras_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign top_vld_o  = vld;
  assign top_addr_o = vld ? rdata : '0;
  assign ckpt_top_o = top_addr_o;
  assign ckpt_ptr_o = ptr;
  assign ckpt_cnt_o = cnt;

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Parametrised return-address stack (RAS) for the fetch-stage predictor. It pushes the link address on predicted calls and pops a predicted target on predicted returns. It survives overflow by circular overwrite of the oldest entry. On a mispredict flush it restores its state from a checkpoint (pointer, count, top entry) so speculative calls and returns are undone. It sits beside the branch predictor table and feeds the next-PC mux.

## Interface
- DEPTH, 16 (RET_STACK_SIZE): number of entries; power of two, ≥2.
- ADDR_W, 32: return-address width.
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridden).
- CNT_W, $clog2(DEPTH+1): occupancy width (derived).
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push_i  in  1  predicted call this cycle.
- push_addr_i  in  ADDR_W  return address to push (PC+4).
- pop_i  in  1  predicted return this cycle.
- top_addr_o  out  ADDR_W  current top entry; 0 when empty.
- top_vld_o  out  1  stack non-empty (cnt≠0).
- ckpt_ptr_o  out  PTR_W  current write pointer, captured by the branch tag.
- ckpt_cnt_o  out  CNT_W  current occupancy.
- ckpt_top_o  out  ADDR_W  equals top_addr_o; captured with the checkpoint.
- restore_i  in  1  mispredict restore.
- restore_ptr_i  in  PTR_W  checkpointed pointer.
- restore_cnt_i  in  CNT_W  checkpointed occupancy, ≤DEPTH.
- restore_top_i  in  ADDR_W  checkpointed top entry.

## Operation
- State: mem[DEPTH], ptr (next free slot), cnt. Top index = ptr−1 mod DEPTH.
- Priority per cycle: restore_i > push/pop. When restore_i is high, push_i and pop_i are ignored.
- Restore: ptr←restore_ptr_i and cnt←restore_cnt_i. If restore_cnt_i≠0, mem[restore_ptr_i−1]←restore_top_i. This repairs a top overwritten by a speculative push.
- Push only: mem[ptr]←push_addr_i, ptr←ptr+1 (wraps), cnt←min(cnt+1, DEPTH). When cnt=DEPTH, the oldest entry is overwritten silently.
- Pop only, cnt≠0: ptr←ptr−1 (wraps), cnt←cnt−1.
- Pop only, cnt=0: no state change (underflow ignored).
- Push+pop, cnt≠0: mem[ptr−1]←push_addr_i; ptr and cnt are unchanged (return immediately followed by a call).
- Push+pop, cnt=0: behaves as push only.
- Output gating:
  - top_addr_o = top_vld_o ? mem[ptr−1] : 0.
  - ckpt_* outputs reflect the current registered state.
- Width rules: pointer arithmetic is modulo 2^PTR_W. cnt never exceeds DEPTH and never goes below 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed upstream): ptr=0, cnt=0. Outputs at reset: top_addr_o=0, top_vld_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0, ckpt_top_o=0. mem is not reset; its contents are hidden by gating.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Latency:
  - A push at edge N makes top_addr_o = push_addr_i in the cycle after edge N.
  - A pop at edge N exposes the previous entry in the cycle after N.
- Restore takes effect at the same edge. The following cycle shows the checkpointed state.
- Back-to-back push/pop every cycle is supported with no bubble.
- Reset asserted mid-operation clears ptr and cnt immediately. There is no drain.

## Structure
- The river_pkg package holds the RET_STACK_SIZE and RET_PRED_POINTER_SIZE defaults. Add to it a ras_ckpt_t struct {ptr, cnt, top} sized from those defaults, so the branch-tag logic can store checkpoints. The module ports stay flat so DEPTH and ADDR_W remain overridable.
- One sub-module: ras_storage, a DEPTH×ADDR_W register array with one write port (we, waddr, wdata) and one asynchronous read port. Write-port select: the restore write, the push write, or the push+pop overwrite, chosen by the top-level logic.
- The control logic (ptr, cnt, priority) lives in ret_addr_stack.

## Test plan
- Reset then pop: pop_i=1 with no push → top_vld_o=0, top_addr_o=0, ckpt_ptr_o=0, ckpt_cnt_o=0.
- LIFO order: push 0x100, 0x200, 0x300 on consecutive cycles, then pop ×3 → top_addr_o reads 0x300, 0x200, 0x100, then 0 with top_vld_o=0.
- Overflow, DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 → cnt=4, ptr=1. Pops yield 0x50, 0x40, 0x30, 0x20, after which top_vld_o=0.
- Push+pop: stack [0x100, 0x200], then push_i=pop_i=1 with 0x900 → top=0x900, cnt=2 unchanged; the next pop exposes 0x100.
- Checkpoint restore:
  - Stack [0xA0, 0xB0]; capture ckpt (ptr=2, cnt=2, top=0xB0).
  - Pop, then push 0xEE (overwrites slot 1).
  - Assert restore_i with the checkpoint, together with push_i → push ignored, top=0xB0, cnt=2.
  - Pop → 0xA0.
- Asynchronous reset mid-run: drop reset_n between edges with cnt=3 → outputs go to 0 immediately, without waiting for a clk edge.
